// File: rtl/adder_sum_accumulator.sv
// Frame accumulator behind the 4-bit adder: sums COUNT beats (or fewer on flush)
// and hands the total, beat count and overflow flag to the sink over valid/ready.
module adder_sum_accumulator #(
    parameter  int SUM_W = 5,
    parameter  int ACC_W = 8,
    parameter  int COUNT = 4,
    localparam int CNT_W = $clog2(COUNT + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SUM_W-1:0] in_sum,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic [CNT_W-1:0] out_count,
    output logic             out_ovf
);

    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(COUNT - 1);

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             ovf;

    logic             accept;
    logic [ACC_W:0]   sum_wide;
    logic [ACC_W-1:0] acc_next;
    logic [CNT_W-1:0] cnt_next;
    logic             ovf_next;
    logic             close_frame;

    // The extra top bit of sum_wide is the carry out of the accumulator.
    always_comb begin
        accept   = in_valid && in_ready;
        sum_wide = {1'b0, acc} + (ACC_W + 1)'(in_sum);
        acc_next = acc;
        cnt_next = cnt;
        ovf_next = ovf;
        if (accept) begin
            acc_next = sum_wide[ACC_W-1:0];
            cnt_next = cnt + CNT_W'(1);
            ovf_next = ovf | sum_wide[ACC_W];
        end
        close_frame = (state == ACC) &&
                      ((accept && (cnt == LAST_BEAT)) ||
                       (flush && ((cnt != '0) || accept)));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ACC;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            out_acc   <= '0;
            out_count <= '0;
            out_ovf   <= 1'b0;
        end else begin
            unique case (state)
                ACC: begin
                    if (close_frame) begin
                        state     <= HOLD;
                        in_ready  <= 1'b0;
                        out_valid <= 1'b1;
                        out_acc   <= acc_next;
                        out_count <= cnt_next;
                        out_ovf   <= ovf_next;
                        acc       <= '0;
                        cnt       <= '0;
                        ovf       <= 1'b0;
                    end else begin
                        acc <= acc_next;
                        cnt <= cnt_next;
                        ovf <= ovf_next;
                    end
                end
                // Output data registers are left untouched after the handshake.
                HOLD: begin
                    if (out_ready) begin
                        state     <= ACC;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adder_sum_accumulator.sv
// Self-checking bench: three accumulator variants share one input stream and are
// compared every cycle against a frame-level model, plus hand-computed literal checks.
module tb_adder_sum_accumulator;

    localparam int N_DUT = 3;
    localparam int FRAME_LEN [N_DUT] = '{4, 4, 1};
    localparam int ACC_WIDTH [N_DUT] = '{8, 6, 8};

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [4:0] in_sum;
    logic       flush;
    logic       out_ready;

    logic       a_in_ready, a_out_valid, a_out_ovf;
    logic [7:0] a_out_acc;
    logic [2:0] a_out_count;

    logic       b_in_ready, b_out_valid, b_out_ovf;
    logic [5:0] b_out_acc;
    logic [2:0] b_out_count;

    logic       c_in_ready, c_out_valid, c_out_ovf;
    logic [7:0] c_out_acc;
    logic [0:0] c_out_count;

    logic obs_in_ready  [N_DUT];
    logic obs_out_valid [N_DUT];
    logic obs_ovf       [N_DUT];
    int   obs_acc       [N_DUT];
    int   obs_cnt       [N_DUT];

    int   checks = 0;
    int   errors = 0;

    // Frame-level model state: running true sum and beat count of the open frame
    bit   model_live = 1'b0;
    bit   m_hold [N_DUT];
    int   m_sum  [N_DUT];
    int   m_n    [N_DUT];
    int   e_acc  [N_DUT];
    int   e_cnt  [N_DUT];
    bit   e_ovf  [N_DUT];

    int   seq_basic [4] = '{3, 7, 12, 31};
    int   seq_ovf   [4] = '{31, 31, 31, 1};

    always #5 clk = ~clk;

    adder_sum_accumulator u_dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_sum(in_sum), .flush(flush), .out_valid(a_out_valid), .out_ready(out_ready),
        .out_acc(a_out_acc), .out_count(a_out_count), .out_ovf(a_out_ovf)
    );

    adder_sum_accumulator #(.ACC_W(6)) u_dut_w6 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_sum(in_sum), .flush(flush), .out_valid(b_out_valid), .out_ready(out_ready),
        .out_acc(b_out_acc), .out_count(b_out_count), .out_ovf(b_out_ovf)
    );

    adder_sum_accumulator #(.COUNT(1)) u_dut_c1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(c_in_ready),
        .in_sum(in_sum), .flush(flush), .out_valid(c_out_valid), .out_ready(out_ready),
        .out_acc(c_out_acc), .out_count(c_out_count), .out_ovf(c_out_ovf)
    );

    assign obs_in_ready[0]  = a_in_ready;
    assign obs_in_ready[1]  = b_in_ready;
    assign obs_in_ready[2]  = c_in_ready;
    assign obs_out_valid[0] = a_out_valid;
    assign obs_out_valid[1] = b_out_valid;
    assign obs_out_valid[2] = c_out_valid;
    assign obs_ovf[0]       = a_out_ovf;
    assign obs_ovf[1]       = b_out_ovf;
    assign obs_ovf[2]       = c_out_ovf;
    assign obs_acc[0]       = int'(a_out_acc);
    assign obs_acc[1]       = int'(b_out_acc);
    assign obs_acc[2]       = int'(c_out_acc);
    assign obs_cnt[0]       = int'(a_out_count);
    assign obs_cnt[1]       = int'(b_out_count);
    assign obs_cnt[2]       = int'(c_out_count);

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one cycle of inputs; returns 2 time units after the edge that consumed them
    task automatic applyStimulus(input logic v, input int s, input logic f,
                                 input logic r, input logic rn);
        in_valid  = v;
        in_sum    = 5'(s);
        flush     = f;
        out_ready = r;
        rst_n     = rn;
        @(posedge clk);
        #2;
    endtask

    // A frame closes when it holds its full beat count, or on flush if non-empty.
    // The true (unwrapped) sum gives both the modular total and the overflow flag.
    always @(posedge clk) begin
        if (!rst_n) model_live <= 1'b1;
        for (int i = 0; i < N_DUT; i++) begin
            automatic int s = m_sum[i];
            automatic int n = m_n[i];
            if (!rst_n) begin
                m_hold[i] <= 1'b0;
                m_sum[i]  <= 0;
                m_n[i]    <= 0;
                e_acc[i]  <= 0;
                e_cnt[i]  <= 0;
                e_ovf[i]  <= 1'b0;
            end else if (m_hold[i]) begin
                if (out_ready) m_hold[i] <= 1'b0;
            end else begin
                if (in_valid) begin
                    s = s + int'(in_sum);
                    n = n + 1;
                end
                if (n == FRAME_LEN[i] || (flush && n > 0)) begin
                    e_acc[i]  <= s % (1 << ACC_WIDTH[i]);
                    e_cnt[i]  <= n;
                    e_ovf[i]  <= (s >= (1 << ACC_WIDTH[i]));
                    m_hold[i] <= 1'b1;
                    m_sum[i]  <= 0;
                    m_n[i]    <= 0;
                end else begin
                    m_sum[i] <= s;
                    m_n[i]   <= n;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (model_live) begin
            for (int i = 0; i < N_DUT; i++) begin
                checkOutput($sformatf("cyc in_ready[%0d]", i), int'(obs_in_ready[i]), int'(!m_hold[i]));
                checkOutput($sformatf("cyc out_valid[%0d]", i), int'(obs_out_valid[i]), int'(m_hold[i]));
                checkOutput($sformatf("cyc out_acc[%0d]", i), obs_acc[i], e_acc[i]);
                checkOutput($sformatf("cyc out_count[%0d]", i), obs_cnt[i], e_cnt[i]);
                checkOutput($sformatf("cyc out_ovf[%0d]", i), int'(obs_ovf[i]), int'(e_ovf[i]));
            end
        end
    end

    initial begin
        // Reset and basic frame
        applyStimulus(0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("rst out_valid", int'(a_out_valid), 0);
        checkOutput("rst in_ready", int'(a_in_ready), 1);
        checkOutput("rst out_acc", obs_acc[0], 0);
        checkOutput("rst out_count", obs_cnt[0], 0);
        foreach (seq_basic[k]) applyStimulus(1, seq_basic[k], 0, 1, 1);
        checkOutput("basic out_valid", int'(a_out_valid), 1);
        checkOutput("basic out_acc", obs_acc[0], 53);
        checkOutput("basic out_count", obs_cnt[0], 4);
        checkOutput("basic out_ovf", int'(a_out_ovf), 0);
        applyStimulus(0, 0, 0, 1, 1);
        checkOutput("basic drop out_valid", int'(a_out_valid), 0);
        checkOutput("basic in_ready back", int'(a_in_ready), 1);

        // Backpressure: beats offered during HOLD must not be consumed
        repeat (4) applyStimulus(1, 10, 0, 0, 1);
        checkOutput("bp out_acc", obs_acc[0], 40);
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1, 5, 0, 0, 1);
            checkOutput("bp hold out_valid", int'(a_out_valid), 1);
            checkOutput("bp hold out_acc", obs_acc[0], 40);
            checkOutput("bp hold in_ready", int'(a_in_ready), 0);
        end
        applyStimulus(1, 5, 0, 1, 1);
        checkOutput("bp release out_valid", int'(a_out_valid), 0);
        checkOutput("bp release in_ready", int'(a_in_ready), 1);
        repeat (4) applyStimulus(1, 1, 0, 1, 1);
        checkOutput("bp next out_acc", obs_acc[0], 4);
        applyStimulus(0, 0, 0, 1, 1);

        // Overflow on the 6-bit variant, and the flag clears between frames
        foreach (seq_ovf[k]) applyStimulus(1, seq_ovf[k], 0, 1, 1);
        checkOutput("ovf w6 out_acc", obs_acc[1], 30);
        checkOutput("ovf w6 out_ovf", int'(b_out_ovf), 1);
        checkOutput("ovf w6 out_count", obs_cnt[1], 4);
        checkOutput("ovf w8 out_acc", obs_acc[0], 94);
        checkOutput("ovf w8 out_ovf", int'(a_out_ovf), 0);
        applyStimulus(0, 0, 0, 1, 1);
        repeat (4) applyStimulus(1, 1, 0, 1, 1);
        checkOutput("ovf clear out_acc", obs_acc[1], 4);
        checkOutput("ovf clear out_ovf", int'(b_out_ovf), 0);
        applyStimulus(0, 0, 0, 1, 1);

        // Flush with a same-cycle beat, then an empty flush
        applyStimulus(1, 5, 0, 1, 1);
        applyStimulus(1, 6, 0, 1, 1);
        applyStimulus(1, 2, 1, 1, 1);
        checkOutput("flush out_valid", int'(a_out_valid), 1);
        checkOutput("flush out_acc", obs_acc[0], 13);
        checkOutput("flush out_count", obs_cnt[0], 3);
        applyStimulus(0, 0, 0, 1, 1);
        applyStimulus(0, 0, 1, 1, 1);
        checkOutput("empty flush out_valid", int'(a_out_valid), 0);
        applyStimulus(0, 0, 0, 1, 1);
        checkOutput("empty flush later out_valid", int'(a_out_valid), 0);

        // Reset mid-frame discards partial beats; reset in HOLD drops out_valid
        applyStimulus(1, 2, 0, 1, 1);
        applyStimulus(1, 2, 0, 1, 1);
        applyStimulus(0, 0, 0, 1, 0);
        repeat (4) applyStimulus(1, 1, 0, 1, 1);
        checkOutput("midrst out_acc", obs_acc[0], 4);
        checkOutput("midrst out_count", obs_cnt[0], 4);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("holdrst out_valid", int'(a_out_valid), 0);
        checkOutput("holdrst in_ready", int'(a_in_ready), 1);
        applyStimulus(0, 0, 0, 1, 1);

        // Gapped input
        for (int k = 1; k <= 4; k++) begin
            applyStimulus(1, k, 0, 1, 1);
            if (k < 4) applyStimulus(0, 0, 0, 1, 1);
        end
        checkOutput("gap out_acc", obs_acc[0], 10);
        checkOutput("gap out_count", obs_cnt[0], 4);

        // Single-beat frames
        applyStimulus(0, 0, 0, 1, 0);
        applyStimulus(1, 9, 0, 1, 1);
        checkOutput("c1 out_valid", int'(c_out_valid), 1);
        checkOutput("c1 out_acc", obs_acc[2], 9);
        checkOutput("c1 out_count", obs_cnt[2], 1);
        applyStimulus(0, 0, 0, 1, 1);

        // Randomized traffic with occasional flush, backpressure and reset
        for (int k = 0; k < 3000; k++) begin
            applyStimulus(logic'($urandom_range(0, 3) != 0),
                          int'($urandom_range(0, 31)),
                          logic'($urandom_range(0, 7) == 0),
                          logic'($urandom_range(0, 2) != 0),
                          logic'($urandom_range(0, 199) != 0));
        end
        applyStimulus(0, 0, 0, 1, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
